// File: rtl/encrypt_collect.sv
// Packs byte-serial ciphertext MSB-first into NBYTES-wide blocks and offers
// each block through a single holding register on a valid/ready handshake.
module encrypt_collect #(
   parameter int NBYTES = 16,
   parameter int CW     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   input  logic                  flush,
   input  logic                  block_ready,
   output logic [8*NBYTES-1:0]   block_data,
   output logic                  block_valid,
   output logic [CW-1:0]         byte_cnt,
   output logic                  overflow
);

   localparam int W = 8 * NBYTES;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } hold_e;

   hold_e          hold_q, hold_d;
   logic [W-1:0]   fill_q, fill_d;
   logic [W-1:0]   data_q, data_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           ovf_q, ovf_d;
   logic           accept;
   logic [W-1:0]   shifted;

   always_comb begin
      hold_d  = hold_q;
      fill_d  = fill_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      accept  = (hold_q == FULL) && block_ready;
      shifted = {fill_q[W-9:0], in_data};

      if (accept) hold_d = EMPTY;

      if (flush) begin
         fill_d = '0;
         cnt_d  = '0;
         ovf_d  = 1'b0;
      end else if (in_valid) begin
         fill_d = shifted;
         if (cnt_q == CW'(NBYTES - 1)) begin
            cnt_d = '0;
            // The encryptor cannot stall: a block with nowhere to go is lost.
            if ((hold_q == EMPTY) || accept) begin
               data_d = shifted;
               hold_d = FULL;
            end else begin
               ovf_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= EMPTY;
         fill_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         fill_q <= fill_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   assign block_data  = data_q;
   assign block_valid = (hold_q == FULL);
   assign byte_cnt    = cnt_q;
   assign overflow    = ovf_q;

endmodule

// File: doc/encrypt_collect.md
Name: encrypt_collect

Overview:
- Downstream stage of the byte-serial AES encryptor.
- Captures each ciphertext byte presented with the encryptor's output strobe, MSB-first, and packs 16 bytes into a 128-bit block.
- Offers the block to the system side on a valid/ready handshake, with one holding register so collection of the next block continues while the previous block waits.
- The encryptor cannot be stalled. A completed block that finds the holding register still occupied is dropped, and a sticky overflow flag is set.

Parameters:
- NBYTES, 16, number of bytes per block. Block width is 8*NBYTES.
- CW, 4, byte counter width. Must satisfy 2**CW >= NBYTES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_data  in  8  ciphertext byte from the encryptor's output_data.
- in_valid  in  1  byte strobe from the encryptor's output_ready; in_data is captured on every clock edge where this is high.
- flush  in  1  synchronous abort of the partially filled block.
- block_ready  in  1  consumer accepts block_data.
- block_data  out  8*NBYTES  assembled block; the first byte received is in bits [8*NBYTES-1 : 8*NBYTES-8].
- block_valid  out  1  block_data holds an unconsumed block.
- byte_cnt  out  CW  number of bytes in the partial block.
- overflow  out  1  sticky; at least one completed block has been dropped.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (rst=0), applied immediately and independent of clk:
  - fill register, byte_cnt, block_data, block_valid and overflow all go to 0.
  - A partial block in progress is discarded.
  - After release, the first in_valid byte starts a new block.
- Fill path:
  - On an edge with in_valid=1 and flush=0: fill <= {fill[8*NBYTES-9:0], in_data}.
  - If byte_cnt < NBYTES-1, byte_cnt increments.
  - If byte_cnt = NBYTES-1, the byte completes the block and byte_cnt wraps to 0 on that edge.
  - in_valid=0 edges leave fill and byte_cnt unchanged. Gaps of any length between bytes are legal.
- Holding register, two states:
  - EMPTY: block_valid=0.
  - FULL: block_valid=1, and block_data is stable until accepted.
  - Handshake: the block is accepted on an edge where block_valid=1 and block_ready=1.
  - FULL to EMPTY on acceptance, when no completed block arrives on the same edge.
- Completing byte, evaluated on that edge:
  - Holding register EMPTY, or accepted on the same edge: block_data <= {fill[8*NBYTES-9:0], in_data} and block_valid=1. A simultaneous accept and load keeps block_valid=1 continuously, with no bubble.
  - Holding register FULL and not accepted: the completed block is discarded, overflow <= 1, and block_data and block_valid are unchanged.
- Latency: block_valid is high in the cycle immediately after the edge that captures the last byte. block_ready has no combinational path to any output.
- flush=1:
  - byte_cnt <= 0 and fill <= 0.
  - overflow <= 0.
  - Any in_valid byte on the same edge is discarded; flush has priority.
  - The holding register and an in-progress handshake are unaffected.
- overflow is cleared only by reset or flush.
- block_ready while block_valid=0 has no effect.

Test Plan:
1. Reset behaviour:
   - Stimulus: drive rst=0 mid-simulation with in_valid toggling.
   - Required: block_data=0, block_valid=0, byte_cnt=0, overflow=0 without waiting for a clock edge; outputs stay 0 until bytes arrive after release.
2. Basic block:
   - Stimulus: block_ready=1; stream 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a on consecutive cycles.
   - Required: one cycle after the 16th edge, block_valid=1 and block_data=128'h69c4e0d86a7b0430d8cdb78070b4c55a; byte_cnt=0; block_valid drops the next cycle.
3. Gapped input and flush:
   - Stimulus: stream the same 16 bytes with in_valid low for 1–3 cycles between bytes.
   - Required: identical block_data.
   - Stimulus: send 7 bytes, then flush.
   - Required: byte_cnt=0.
   - Stimulus: send bytes 00..0f.
   - Required: block_data=128'h000102030405060708090a0b0c0d0e0f.
   - Stimulus: assert flush and in_valid on the same edge.
   - Required: the byte is not counted.
4. Overflow:
   - Stimulus: block_ready=0; send vector A (from scenario 2), then bytes 00..0f.
   - Required: overflow=1 after the 32nd byte edge; block_data still equals A.
   - Stimulus: raise block_ready.
   - Required: one handshake, then block_valid=0; overflow stays 1 until flush.
5. Simultaneous accept and load:
   - Stimulus: holding register has A; raise block_ready on exactly the edge of the 16th byte of block 00..0f.
   - Required: block_valid stays 1 continuously; block_data becomes 000102..0f; overflow=0.
6. Reset mid-block:
   - Stimulus: after 9 bytes, pulse rst=0 asynchronously (between edges).
   - Required: byte_cnt=0 immediately; no block_valid pulse.
   - Stimulus: send 16 fresh bytes.
   - Required: they form a correct block.
